// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: parity modes,
// serialiser state codes and the data-length floor.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int unsigned MIN_DATA_BITS = 5;

  // Encoding 2'b11 is an alias for "no parity".
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART serialiser.
// Occupancy and full/empty come from pointers carrying one extra wrap bit.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

  assign w_pop  = i_rd_en && !o_empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign w_push = i_wr_en && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overflow <= i_wr_en && !w_push;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: FIFO, baud tick generator and
// frame serialiser. Frame settings are captured when a word is popped.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 16,
  parameter int SAMPLING_TICKS = 16,
  parameter int DIV_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  input  logic                     tx_en,
  input  logic                     cts_n,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PH_W = (SAMPLING_TICKS > 1) ? $clog2(SAMPLING_TICKS) : 1;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [3:0]       r_nbits;
  logic [3:0]       r_bit_cnt;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_stop2;
  logic             r_stop_cnt;
  logic             r_tx;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic [PH_W-1:0]  r_phase;

  logic [WIDTH-1:0] w_fifo_dout;
  logic [WIDTH-1:0] w_mask;
  logic [3:0]       w_nbits;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_start;
  logic             w_tick;
  logic             w_bit_done;

  tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (wr_en),
    .i_data     (data_in),
    .i_rd_en    (w_start),
    .o_data     (w_fifo_dout),
    .o_full     (full),
    .o_empty    (empty),
    .o_level    (level),
    .o_overflow (overflow)
  );

  assign tx   = r_tx;
  assign busy = (r_state != ST_IDLE);

  assign w_start   = (r_state == ST_IDLE) && tx_en && !cts_n && !empty;
  assign w_div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;

  always_comb begin
    w_nbits = cfg_data_bits;
    if ((cfg_data_bits < 4'(MIN_DATA_BITS)) || (cfg_data_bits > 4'(WIDTH)))
      w_nbits = 4'(WIDTH);
    w_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      w_mask[i] = (i < 32'(w_nbits));
  end

  assign w_tick     = (r_div_cnt == r_div - DIV_W'(1));
  assign w_bit_done = w_tick && (r_phase == PH_W'(SAMPLING_TICKS - 1));

  // Held at zero while idle so every frame starts on a fresh bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_phase   <= '0;
    end else if (r_state == ST_IDLE) begin
      r_div_cnt <= '0;
      r_phase   <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_phase   <= (r_phase == PH_W'(SAMPLING_TICKS - 1)) ? '0 : r_phase + 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_nbits    <= '0;
      r_bit_cnt  <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_div      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_start) begin
            r_state    <= ST_START;
            r_tx       <= 1'b0;
            r_shift    <= w_fifo_dout;
            r_nbits    <= w_nbits;
            r_bit_cnt  <= '0;
            r_par_en   <= par_enabled(cfg_parity);
            r_par_bit  <= (^(w_fifo_dout & w_mask)) ^ (cfg_parity == PAR_ODD);
            r_stop2    <= cfg_stop2;
            r_stop_cnt <= 1'b0;
            r_div      <= w_div_eff;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            if (r_bit_cnt == r_nbits - 4'd1) begin
              r_bit_cnt <= '0;
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_done) begin
            if (r_stop2 && !r_stop_cnt) r_stop_cnt <= 1'b1;
            else                        r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: a line monitor compares each frame
// on tx against a frame description derived from the pushed word and config.
module tb_uart_tx_cfg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int ST    = 16;
  localparam int DIV_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   wr_en;
  logic [WIDTH-1:0]       data_in;
  logic [DIV_W-1:0]       baud_div;
  logic [3:0]             cfg_data_bits;
  logic [1:0]             cfg_parity;
  logic                   cfg_stop2;
  logic                   tx_en;
  logic                   cts_n;
  logic                   tx;
  logic                   busy;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;

  uart_tx_cfg #(
    .WIDTH          (WIDTH),
    .DEPTH          (DEPTH),
    .SAMPLING_TICKS (ST),
    .DIV_W          (DIV_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .data_in       (data_in),
    .baud_div      (baud_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_en         (tx_en),
    .cts_n         (cts_n),
    .tx            (tx),
    .busy          (busy),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] word;
    int unsigned      bitp;
    int unsigned      nb;
    int unsigned      par;   // 0 none, 1 even, 2 odd
    bit               stop2;
  } frame_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  frame_t      exp_q[$];
  longint unsigned start_times[$];
  longint unsigned cyc = 0;
  int unsigned ovf_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t mk_frame(input logic [WIDTH-1:0] w);
    frame_t f;
    int unsigned d;
    d = (baud_div == 0) ? 1 : int'(baud_div);
    f.word  = w;
    f.bitp  = d * ST;
    f.nb    = (cfg_data_bits < 5 || cfg_data_bits > WIDTH) ? WIDTH : int'(cfg_data_bits);
    f.par   = (cfg_parity == 2'b01) ? 1 : (cfg_parity == 2'b10) ? 2 : 0;
    f.stop2 = cfg_stop2;
    return f;
  endfunction

  function automatic int unsigned frame_len(input frame_t f);
    return (1 + f.nb + ((f.par != 0) ? 1 : 0) + 1 + (f.stop2 ? 1 : 0)) * f.bitp;
  endfunction

  // Line level of bit slot k: start, data LSB first, optional parity, stops.
  function automatic logic exp_bit(input frame_t f, input int unsigned k);
    int unsigned m;
    int unsigned ones;
    if (k == 0) return 1'b0;
    if (k <= f.nb) return f.word[k-1];
    if (f.par != 0 && k == f.nb + 1) begin
      m = (1 << f.nb) - 1;
      ones = $countones(32'(f.word) & m);
      return logic'(ones % 2) ^ (f.par == 2);
    end
    return 1'b1;
  endfunction

  bit          mon_act = 0;
  bit          mon_bogus = 0;
  int unsigned mon_t;
  int unsigned mon_len;
  frame_t      mon_f;

  always @(negedge clk) begin
    cyc++;
    if (overflow === 1'b1) ovf_cnt++;
    if (!rst_n) begin
      mon_act   = 0;
      mon_bogus = 0;
    end else begin
      if (tx === 1'b1) mon_bogus = 0;
      if (!mon_act && !mon_bogus && tx !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(tx), 32'd1);
          mon_bogus = 1;
        end else begin
          mon_f   = exp_q.pop_front();
          mon_len = frame_len(mon_f);
          mon_t   = 0;
          mon_act = 1;
          start_times.push_back(cyc);
          chk("busy_at_start", 32'(busy), 32'd1);
        end
      end
      if (mon_act) begin
        if (mon_t == mon_len) begin
          chk("busy_after_frame", 32'(busy), 32'd0);
          chk("tx_after_frame", 32'(tx), 32'd1);
          mon_act = 0;
        end else begin
          if (mon_t % mon_f.bitp == mon_f.bitp / 2) begin
            chk($sformatf("bit%0d_w%0h", mon_t / mon_f.bitp, mon_f.word),
                32'(tx), 32'(exp_bit(mon_f, mon_t / mon_f.bitp)));
            chk("busy_in_frame", 32'(busy), 32'd1);
          end
          mon_t++;
        end
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] w, input bit accept);
    wr_en   = 1'b1;
    data_in = w;
    if (accept) exp_q.push_back(mk_frame(w));
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || mon_act || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  task automatic set_cfg(input int unsigned div, input int unsigned nb,
                         input int unsigned par, input bit s2);
    baud_div      = DIV_W'(div);
    cfg_data_bits = 4'(nb);
    cfg_parity    = 2'(par);
    cfg_stop2     = s2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    rst_n = 1'b0; wr_en = 1'b0; data_in = '0;
    set_cfg(1, 8, 0, 0);
    tx_en = 1'b1; cts_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // 8N1 at divisor 1, including pop latency.
    push(8'h55, 1);
    chk("lat_empty", 32'(empty), 32'd0);
    chk("lat_level", 32'(level), 32'd1);
    chk("lat_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_tx", 32'(tx), 32'd0);
    chk("start_level", 32'(level), 32'd0);
    wait_idle(400);

    // 7E2 at divisor 3.
    set_cfg(3, 7, 1, 1);
    push(8'h41, 1);
    wait_idle(1200);

    // Parity extremes, odd then even.
    set_cfg(1, 8, 2, 0);
    push(8'hFF, 1); push(8'h00, 1);
    wait_idle(800);
    set_cfg(1, 8, 1, 0);
    push(8'hFF, 1); push(8'h00, 1);
    wait_idle(800);

    // Fill past capacity while blocked, then drain back-to-back.
    set_cfg(1, 8, 0, 0);
    cts_n = 1'b1;
    ovf_cnt = 0;
    for (int i = 0; i < 17; i++) push(WIDTH'($urandom), i < 16);
    @(negedge clk); @(negedge clk);
    chk("ovf_pulses", ovf_cnt, 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_busy", 32'(busy), 32'd0);
    start_times.delete();
    cts_n = 1'b0;
    wait_idle(16 * 200);
    chk("drain_frames", start_times.size(), 32'd16);
    for (int i = 1; i < start_times.size(); i++)
      chk($sformatf("gap%0d", i), 32'(start_times[i] - start_times[i-1]), 32'd161);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_full", 32'(full), 32'd0);

    // Flow control raised mid-frame.
    push(8'hA5, 1);
    push(8'h3C, 1);
    repeat (40) @(negedge clk);
    cts_n = 1'b1;
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk("cts_frame_end", 32'(n < 400), 32'd1);
    repeat (200) @(negedge clk);
    chk("cts_hold_busy", 32'(busy), 32'd0);
    chk("cts_hold_tx", 32'(tx), 32'd1);
    chk("cts_hold_level", 32'(level), 32'd1);
    chk("cts_hold_pending", exp_q.size(), 32'd1);
    cts_n = 1'b0;
    wait_idle(400);

    // Randomised frames; single-word bursts also scramble config mid-frame.
    for (int it = 0; it < 20; it++) begin
      int unsigned nw;
      set_cfg($urandom_range(0, 2), $urandom_range(0, 15),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      nw = $urandom_range(1, 3);
      for (int k = 0; k < int'(nw); k++) push(WIDTH'($urandom), 1);
      if (nw == 1) begin
        repeat (20) @(negedge clk);
        set_cfg($urandom_range(0, 2), $urandom_range(0, 15),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      wait_idle(2000);
    end

    // Reset in the middle of the data bits with a word still queued.
    set_cfg(1, 8, 0, 0);
    push(8'h00, 1);
    push(8'h00, 1);
    repeat (36) @(negedge clk);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_tx", 32'(tx), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
